addsub_accum: RTL and testbench
===============================

# addsub_accum

Sequential accumulator stage that sits directly downstream of the 4-bit adder-subtractor datapath. It accepts a stream of add/subtract commands over a valid/ready handshake and applies each operand to a registered two's-complement accumulator. It reports the result and a per-operation overflow flag over a second handshake, and keeps a sticky overflow flag until it is cleared. The combinational add/sub arithmetic is instantiated inside this block as a sub-module, and this block owns all state.

## Interface
- WIDTH, 4, accumulator and operand width in bits (two's complement, minimum 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  command present
- in_ready  output  1  block can accept a command
- in_b  input  WIDTH  operand
- in_sub  input  1  0 = add (acc + in_b), 1 = subtract (acc − in_b)
- in_clr  input  1  use 0 instead of acc as the left operand (load / negate-load)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_acc  output  WIDTH  accumulator value after the last command
- out_ovf  output  1  signed overflow of the last command
- ovf_sticky  output  1  OR of out_ovf since reset or the last in_clr command

## Operation
- Clocking and reset:
  - Single clock `clk`.
  - Reset `rst_n` is asynchronous and active-low.
  - Reset values: state=IDLE, acc=0, out_ovf=0, ovf_sticky=0, in_ready=1, out_valid=0.
- FSM states: IDLE, CALC, RESP.
  - IDLE: in_ready=1. If in_valid=1, latch in_b, in_sub and in_clr, then go to CALC.
  - CALC: in_ready=0, out_valid=0.
    - Left operand L = in_clr ? 0 : acc.
    - Compute R = L + (in_sub ? ~in_b : in_b) + in_sub, truncated to WIDTH.
    - Register acc ← R and out_ovf ← ovf.
    - ovf_sticky ← in_clr ? ovf : (ovf_sticky | ovf).
    - Go to RESP.
  - RESP: out_valid=1, in_ready=0. If out_ready=1, go to IDLE. Otherwise hold.
- Overflow is signed overflow only:
  - Let B' = in_sub ? ~in_b : in_b.
  - ovf = (L[MSB] == B'[MSB]) && (R[MSB] != L[MSB]).
  - Carry-out is discarded and not reported.
- Subtract with in_b = most-negative (1000 for WIDTH=4): follows the formula above with no special-casing.
- out_acc always reflects the acc register. It changes only on the CALC→RESP edge.
- Commands are not queued. While in CALC or RESP the block ignores in_valid.

## Timing
- Command accepted on edge N (in_valid & in_ready).
- acc, out_ovf and ovf_sticky update on edge N+1.
- out_valid=1 from edge N+1 onward.
- Response handshake completes on the first edge where out_valid & out_ready.
- in_ready returns high on that same edge.
- Minimum throughput: one command per 3 cycles.
- out_ready held low indefinitely: out_acc, out_ovf and out_valid stay stable.
- out_ready already high when RESP is entered: the handshake completes on the next edge. No combinational path exists from out_ready to out_valid.
- in_ready is a registered function of state. No combinational path exists from in_valid to in_ready.
- rst_n asserted in any state: all outputs return to reset values immediately. The in-flight command is lost and produces no response.

## Configuration
- Macro: ADDSUB_ACCUM_SAT_EN.
- Defined:
  - On ovf, acc saturates to the most-positive value if L[MSB]=0, or to the most-negative value if L[MSB]=1.
  - out_ovf and ovf_sticky are still asserted.
- Undefined: on ovf, acc takes the wrapped R.

## Structure
- Package addsub_pkg holds:
  - the state enum typedef (IDLE, CALC, RESP)
  - the default-WIDTH constant
  - the functions/constants for most-positive and most-negative values of a given width
- Sub-module addsub_core (combinational):
  - inputs: L, in_b, in_sub
  - outputs: R, ovf
- The FSM, the registers and the saturation mux live in addsub_accum.

## Test plan
1. Reset, then add 3 (in_clr=1), then add 4 → first response out_acc=0011, out_ovf=0; second response out_acc=0111, out_ovf=0, ovf_sticky=0.
2. From acc=0111, add 1 → out_acc=1000 (out_ovf=1, ovf_sticky=1) without the macro; out_acc=0111 (out_ovf=1) with ADDSUB_ACCUM_SAT_EN. Next, add 0 → out_ovf=0, ovf_sticky stays 1.
3. in_clr=1 sub 1 → out_acc=1111, out_ovf=0, ovf_sticky=0. Then sub 1000 → out_acc=0111, out_ovf=0. Then from in_clr=1 add 0 (acc=0), sub 1000 → out_acc=1000 (wrap) or 0111 (sat), out_ovf=1.
4. Backpressure: out_ready=0 for 5 cycles during RESP → out_valid stays 1, out_acc stable, in_ready stays 0. in_valid pulsed during this window is ignored (acc unchanged).
5. Throughput: in_valid and out_ready held at 1 with 4 consecutive add-1 commands from acc=0 → responses 1, 2, 3, 4, one accept every 3 cycles.
6. rst_n pulsed low while in CALC → out_valid=0, out_acc=0 and ovf_sticky=0 immediately (asynchronous). No response is issued. The next command behaves as in scenario 1.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub accumulator slice.
//   state_e        : accumulator FSM states
//   DEFAULT_WIDTH  : default operand/accumulator width
//   most_pos/neg   : two's-complement extreme values for a given width,
//                    returned in 32 bits; callers truncate to their width.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

  function automatic logic [31:0] most_pos(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] most_neg(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational two's-complement add/subtract with signed overflow.
//   l_i   : left operand
//   b_i   : right operand
//   sub_i : 0 = l_i + b_i, 1 = l_i - b_i
//   r_o   : result truncated to WIDTH (carry-out discarded)
//   ovf_o : signed overflow of this operation
module addsub_core
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] l_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] r_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] cin;

  always_comb begin
    b_eff = sub_i ? ~b_i : b_i;
    cin   = {{(WIDTH-1){1'b0}}, sub_i};
    r_o   = l_i + b_eff + cin;
    // Overflow judged on the effective operand, so subtracting the most
    // negative value follows the same rule as any other operand.
    ovf_o = (l_i[WIDTH-1] == b_eff[WIDTH-1]) && (r_o[WIDTH-1] != l_i[WIDTH-1]);
  end

endmodule

// File: rtl/addsub_accum.sv
// Registered add/sub accumulator with valid/ready command and response
// handshakes. Each accepted command is applied in CALC and reported in RESP.
//   clk, rst_n     : clock, asynchronous active-low reset
//   in_valid/ready : command handshake (in_b, in_sub, in_clr)
//   out_valid/ready: response handshake (out_acc, out_ovf)
//   ovf_sticky     : OR of out_ovf since reset or the last in_clr command
// Optional feature: define ADDSUB_ACCUM_SAT_EN to saturate acc on overflow
// instead of wrapping.
module addsub_accum
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_ovf,
  output logic             ovf_sticky
);

  state_e           state_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic             clr_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             ovf_q;
  logic             sticky_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] res;
  logic             ovf;

  assign lhs = clr_q ? '0 : acc_q;

  addsub_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .l_i  (lhs),
    .b_i  (b_q),
    .sub_i(sub_q),
    .r_o  (res),
    .ovf_o(ovf)
  );

`ifdef ADDSUB_ACCUM_SAT_EN
  localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(most_pos(WIDTH));
  localparam logic [WIDTH-1:0] MAX_NEG = WIDTH'(most_neg(WIDTH));

  // Overflow direction follows the sign of the left operand.
  always_comb begin
    acc_d = res;
    if (ovf) acc_d = lhs[WIDTH-1] ? MAX_NEG : MAX_POS;
  end
`else
  always_comb begin
    acc_d = res;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      b_q         <= '0;
      sub_q       <= 1'b0;
      clr_q       <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            b_q        <= in_b;
            sub_q      <= in_sub;
            clr_q      <= in_clr;
            state_q    <= CALC;
            in_ready_q <= 1'b0;
          end
        end
        CALC: begin
          acc_q       <= acc_d;
          ovf_q       <= ovf;
          sticky_q    <= clr_q ? ovf : (sticky_q | ovf);
          state_q     <= RESP;
          out_valid_q <= 1'b1;
        end
        RESP: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_acc    = acc_q;
  assign out_ovf    = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_addsub_accum.sv
module tb_addsub_accum;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_b;
  logic       in_sub;
  logic       in_clr;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_acc;
  logic       out_ovf;
  logic       ovf_sticky;

  int unsigned checks = 0;
  int unsigned errors = 0;

`ifdef ADDSUB_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  addsub_accum #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_clr    (in_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .ovf_sticky(ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] b;
    logic       sub;
    logic       clr;
    logic [3:0] acc;
    logic       ovf;
    logic       sticky;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one command and wait for its response to appear (left pending).
  task automatic send(input logic [3:0] b, input logic s, input logic c);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 20), 1);
    in_b = b; in_sub = s; in_clr = c; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_b = ~b; in_sub = ~s; in_clr = ~c;  // operands must have been latched
    chk("in_ready_after_accept", 32'(in_ready), 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("resp_latency", 32'(n), 1);
  endtask

  task automatic respond();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("handshake_out_valid", 32'(out_valid), 0);
    chk("handshake_in_ready", 32'(in_ready), 1);
  endtask

  task automatic chk_resp(input string nm, input logic [3:0] a, input logic o, input logic st);
    chk({nm, "_acc"}, 32'(out_acc), 32'(a));
    chk({nm, "_ovf"}, 32'(out_ovf), 32'(o));
    chk({nm, "_sticky"}, 32'(ovf_sticky), 32'(st));
  endtask

  initial begin
    vec_t vecs[8];
    logic [3:0] held;
    logic [3:0] exp_acc;
    logic       exp_ovf;
    int naccept, nresp, last_acc_cyc, cyc;

    rst_n = 1'b0; in_valid = 1'b0; in_b = '0; in_sub = 1'b0; in_clr = 1'b0; out_ready = 1'b0;

    vecs[0] = '{"clr_add3",  4'd3, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b0};
    vecs[1] = '{"add4",      4'd4, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0};
    vecs[2] = '{"add1_ovf",  4'd1, 1'b0, 1'b0, SAT ? 4'b0111 : 4'b1000, 1'b1, 1'b1};
    vecs[3] = '{"add0",      4'd0, 1'b0, 1'b0, SAT ? 4'b0111 : 4'b1000, 1'b0, 1'b1};
    vecs[4] = '{"clr_sub1",  4'd1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0};
    vecs[5] = '{"sub_neg",   4'b1000, 1'b1, 1'b0, 4'b0111, 1'b0, 1'b0};
    vecs[6] = '{"clr_add0",  4'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0};
    vecs[7] = '{"sub_neg_ovf", 4'b1000, 1'b1, 1'b0, SAT ? 4'b0111 : 4'b1000, 1'b1, 1'b1};

    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk_resp("rst", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenarios 1-3
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].b, vecs[i].sub, vecs[i].clr);
      chk_resp(vecs[i].name, vecs[i].acc, vecs[i].ovf, vecs[i].sticky);
      respond();
    end

    // Backpressure: acc = 1000 (wrap) or 0111 (sat), add 1
    exp_acc = SAT ? 4'b0111 : 4'b1001;
    exp_ovf = SAT;
    send(4'd1, 1'b0, 1'b0);
    chk_resp("bp", exp_acc, exp_ovf, 1'b1);
    held = out_acc;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin in_valid = 1'b1; in_b = 4'd5; in_sub = 1'b0; in_clr = 1'b1; end
      if (c == 4) in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_acc_stable", 32'(out_acc), 32'(held));
    end
    respond();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_ignored_valid", 32'(out_valid), 0);
      chk("bp_ignored_acc", 32'(out_acc), 32'(held));
    end

    // Throughput: clear to 0 then four back-to-back add-1 commands
    send(4'd0, 1'b0, 1'b1);
    chk_resp("tp_clr", 4'd0, 1'b0, 1'b0);
    respond();
    in_b = 4'd1; in_sub = 1'b0; in_clr = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    naccept = 0; nresp = 0; last_acc_cyc = -1; cyc = 0;
    while (nresp < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        chk("tp_resp_acc", 32'(out_acc), 32'(nresp + 1));
        nresp++;
      end
      if (in_ready) begin
        if (naccept == 4) in_valid = 1'b0;
        else begin
          if (last_acc_cyc >= 0) chk("tp_spacing", 32'(cyc - last_acc_cyc), 3);
          last_acc_cyc = cyc;
          naccept++;
        end
      end
    end
    chk("tp_resp_count", 32'(nresp), 4);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("tp_sticky", 32'(ovf_sticky), 0);

    // Set sticky, then reset mid-CALC
    send(4'd7, 1'b0, 1'b0);
    chk_resp("pre_rst", SAT ? 4'b0111 : 4'b1011, 1'b1, 1'b1);
    respond();
    @(negedge clk);
    in_b = 4'd2; in_sub = 1'b0; in_clr = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk_resp("arst", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("arst_no_resp", 32'(out_valid), 0);
    end
    send(4'd3, 1'b0, 1'b1);
    chk_resp("post_rst", 4'b0011, 1'b0, 1'b0);
    respond();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
